// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage: load-mode codes, FSM states and the
// little-endian load aligner.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        LmWord  = 2'b00,
        LmHalf  = 2'b01,
        LmByte  = 2'b10,
        LmByteU = 2'b11
    } load_mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } mem_state_e;

    // Selects the addressed lane of a memory word and extends it to 32 bits.
    function automatic logic [31:0] align_load(input logic [31:0] word,
                                               input logic [1:0]  byte_off,
                                               input load_mode_e  mode);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [31:0] res;
        half_v = byte_off[1] ? word[31:16] : word[15:0];
        byte_v = word[{byte_off, 3'b000} +: 8];
        case (mode)
            LmWord:  res = word;
            LmHalf:  res = {{16{half_v[15]}}, half_v};
            LmByte:  res = {{24{byte_v[7]}}, byte_v};
            default: res = {24'h000000, byte_v};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-organised data memory: synchronous write, asynchronous read. Contents are not reset.
module mem_stage_data_memory #(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] index,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data memory access with configurable latency,
// load alignment, branch resolution and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_RegWrite,
    input  logic        in_MemWrite,
    input  logic        in_MemRead,
    input  logic        in_MemToReg,
    input  logic [1:0]  in_load_mode,
    input  logic [4:0]  in_writebackDestination,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_rt,
    input  logic [31:0] in_pc,
    input  logic        in_zero,
    input  logic        in_branch,
    output logic        PCSrc_out,
    output logic [31:0] branch_target_out,
    output logic        stall_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] memReadData_out,
    output logic [31:0] aluResult_out,
    output logic [4:0]  writebackDestination_out
);

    // Keep at least one counter bit so MEM_LATENCY of 1 or 2 still elaborates.
    localparam int unsigned CntW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stall_raw;
    logic            stall;
    logic            access;
    logic            mem_we;

    logic [ADDR_BITS-1:0] index;
    logic [31:0]          rdata;
    logic [31:0]          load_data;

    logic        regwrite_q;
    logic        memtoreg_q;
    logic [31:0] rdata_q;
    logic [31:0] alu_q;
    logic [4:0]  dest_q;

    assign access = in_MemRead | in_MemWrite;
    assign index  = in_aluResult[ADDR_BITS+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            StIdle: begin
                if (access && (MEM_LATENCY > 1)) begin
                    stall_raw = 1'b1;
                    state_d   = StBusy;
                    cnt_d     = CntW'(MEM_LATENCY - 2);
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q - CntW'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset must abort an access at once: no stall and no write while rst_n is low.
    assign stall     = stall_raw & rst_n;
    assign mem_we    = in_MemWrite & ~stall & rst_n;
    assign stall_out = stall;

    mem_stage_data_memory #(
        .ADDR_BITS(ADDR_BITS)
    ) u_dmem (
        .clk  (clk),
        .we   (mem_we),
        .index(index),
        .wdata(in_rt),
        .rdata(rdata)
    );

    assign load_data = in_MemRead ? align_load(rdata, in_aluResult[1:0], load_mode_e'(in_load_mode))
                                  : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rdata_q    <= '0;
            alu_q      <= '0;
            dest_q     <= '0;
        end else if (stall) begin
            regwrite_q <= 1'b0;
        end else begin
            regwrite_q <= in_RegWrite;
            memtoreg_q <= in_MemToReg;
            rdata_q    <= load_data;
            alu_q      <= in_aluResult;
            dest_q     <= in_writebackDestination;
        end
    end

    assign RegWrite_out             = regwrite_q;
    assign MemToReg_out             = memtoreg_q;
    assign memReadData_out          = rdata_q;
    assign aluResult_out            = alu_q;
    assign writebackDestination_out = dest_q;

    assign PCSrc_out         = in_branch & in_zero;
    assign branch_target_out = in_pc;

endmodule
